// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit.
//   mem_state_t      : FSM states of the bus transaction (IDLE, REQ, DONE)
//   FUNCT3_*         : size/sign encodings of loads and stores
//   access_aligned() : natural-alignment test for a funct3/address pair
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Bytes may sit anywhere, halves need an even address, words a
    // multiple of four. Encodings 011 and 11x have no legal size and are
    // reported as misaligned so they never reach the bus.
    function automatic logic access_aligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: ok = 1'b1;
            FUNCT3_LH, FUNCT3_LHU: ok = ~addr_lo[0];
            FUNCT3_LW:             ok = (addr_lo == 2'b00);
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: combinational load-data extraction.
// Picks the addressed byte or halfword out of the bus read word and
// sign- or zero-extends it according to funct3.
//   rdata     in  32  word returned by data memory
//   offset    in  2   byte offset of the access within the word
//   funct3    in  3   size/sign of the load
//   load_data out 32  extended result
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Half selection only looks at offset[1]; alignment was checked upstream.
    assign byte_val = lane[offset];
    assign half_val = {lane[{offset[1], 1'b1}], lane[{offset[1], 1'b0}]};

    always_comb begin
        load_data = rdata;
        case (funct3)
            FUNCT3_LB:  load_data = {{24{byte_val[7]}}, byte_val};
            FUNCT3_LH:  load_data = {{16{half_val[15]}}, half_val};
            FUNCT3_LBU: load_data = {24'h000000, byte_val};
            FUNCT3_LHU: load_data = {16'h0000, half_val};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder for the EX/MEM pipeline register.
// Turns a load/store in the MEM stage into one req/ack transaction on the
// data-memory bus, stalls the pipeline until it completes, and presents the
// size/sign-corrected load result to MEM/WB. Misaligned accesses and bus
// timeouts are reported as one-cycle pulses.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m_MemRead, m_MemWrite         access request from EX/MEM (write wins)
//   m_funct3, m_alu_out           size/sign and byte address
//   m_mem_data                    store data in low bits
//   stall                         freeze upstream pipeline while high
//   load_data                     extended load result (held until next load)
//   misalign, bus_err             one-cycle error pulses
//   dmem_req/we/addr/be/wdata     bus request, held stable until ack
//   dmem_ack, dmem_rdata          bus completion and read word
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic [2:0]  m_funct3,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    mem_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      addr_reg, addr_next;
    logic             we_reg, we_next;
    logic [3:0]       be_reg, be_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [2:0]       funct3_reg, funct3_next;
    logic [1:0]       offset_reg, offset_next;
    logic [31:0]      load_data_reg, load_data_next;
    logic             misalign_reg, misalign_next;
    logic             bus_err_reg, bus_err_next;
    logic             stall_c;

    logic             access;
    logic             aligned;
    logic             timeout_hit;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      aligned_rdata;

    assign access      = m_MemRead | m_MemWrite;
    assign aligned     = access_aligned(m_funct3, m_alu_out[1:0]);
    assign timeout_hit = TIMEOUT_EN && (cnt_reg == CNT_LAST);

    // Store lane steering: each byte lane decides its own enable and data.
    // Sub-word data is replicated across lanes so memory can take any lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            assign st_be[gi] = (m_funct3[1:0] == 2'b00) ? (m_alu_out[1:0] == 2'(gi))
                             : (m_funct3[1:0] == 2'b01) ? (m_alu_out[1] == (gi >= 2))
                             : 1'b1;
            assign st_wdata[8*gi +: 8] = (m_funct3[1:0] == 2'b00) ? m_mem_data[7:0]
                                       : (m_funct3[1:0] == 2'b01) ? m_mem_data[8*(gi%2) +: 8]
                                       : m_mem_data[8*gi +: 8];
        end
    endgenerate

    mem_load_align u_load_align (
        .rdata     (dmem_rdata),
        .offset    (offset_reg),
        .funct3    (funct3_reg),
        .load_data (aligned_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            funct3_reg    <= '0;
            offset_reg    <= '0;
            load_data_reg <= '0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            funct3_reg    <= funct3_next;
            offset_reg    <= offset_next;
            load_data_reg <= load_data_next;
            misalign_reg  <= misalign_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        funct3_next    = funct3_reg;
        offset_next    = offset_reg;
        load_data_next = load_data_reg;
        misalign_next  = 1'b0;
        bus_err_next   = 1'b0;
        stall_c        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        // Stall combinationally so EX/MEM holds this access
                        // while the latched copy drives the bus.
                        stall_c     = 1'b1;
                        state_next  = REQ;
                        cnt_next    = '0;
                        addr_next   = {m_alu_out[31:2], 2'b00};
                        we_next     = m_MemWrite;
                        be_next     = st_be;
                        wdata_next  = st_wdata;
                        funct3_next = m_funct3;
                        offset_next = m_alu_out[1:0];
                    end else begin
                        misalign_next = 1'b1;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    state_next = DONE;
                    if (!we_reg) begin
                        load_data_next = aligned_rdata;
                    end
                end else if (timeout_hit) begin
                    state_next     = DONE;
                    bus_err_next   = 1'b1;
                    load_data_next = '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // Inputs still show the finished access here; the pipeline
                // advances at the end of this cycle, so never re-issue.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stall      = stall_c;
    assign load_data  = load_data_reg;
    assign misalign   = misalign_reg;
    assign bus_err    = bus_err_reg;
    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_be    = be_reg;
    assign dmem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit (TIMEOUT_CYCLES = 4).
// Expected bus transactions are queued when an access is driven and popped
// when the DUT raises dmem_req.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_MemRead = 1'b0;
    logic        m_MemWrite = 1'b0;
    logic [2:0]  m_funct3 = 3'b000;
    logic [31:0] m_alu_out = 32'h0;
    logic [31:0] m_mem_data = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ld = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_MemRead  (m_MemRead),
        .m_MemWrite (m_MemWrite),
        .m_funct3   (m_funct3),
        .m_alu_out  (m_alu_out),
        .m_mem_data (m_mem_data),
        .stall      (stall),
        .load_data  (load_data),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One aligned access: drive, find the request, ack after ack_wait idle
    // REQ cycles, then check DONE and the following IDLE cycle.
    task automatic issue(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int ack_wait,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
        exp_t e;
        int   stalls;
        int   n;
        e.addr  = {a[31:2], 2'b00};
        e.we    = wr;
        e.be    = exp_be;
        e.wdata = exp_wdata;
        e.ld    = exp_ld;
        sb_q.push_back(e);
        m_MemRead = rd; m_MemWrite = wr; m_funct3 = f3; m_alu_out = a; m_mem_data = d;
        #1;
        stalls = (stall === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        n = 0;
        while (dmem_req !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req: dmem_req=%b required 1", name, dmem_req);
        end
        e = sb_q.pop_front();
        checks++;
        if (dmem_addr !== e.addr || dmem_we !== e.we ||
            (e.we && (dmem_be !== e.be || dmem_wdata !== e.wdata))) begin
            errors++;
            $display("FAIL %s_bus: addr=%h we=%b be=%b wdata=%h required addr=%h we=%b be=%b wdata=%h",
                     name, dmem_addr, dmem_we, dmem_be, dmem_wdata, e.addr, e.we, e.be, e.wdata);
        end
        for (int k = 0; k <= ack_wait; k++) begin
            if (stall === 1'b1) stalls++;
            if (k == ack_wait) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end else begin
                dmem_rdata = 32'h5A5A_5A5A;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        checks++;
        if (stalls != ack_wait + 2) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d required %0d", name, stalls, ack_wait + 2);
        end
        checks++;
        if ({stall, dmem_req, bus_err, misalign} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_done: stall=%b req=%b bus_err=%b misalign=%b required all 0",
                     name, stall, dmem_req, bus_err, misalign);
        end
        checks++;
        if (load_data !== e.ld) begin
            errors++;
            $display("FAIL %s_load_data: got %h required %h", name, load_data, e.ld);
        end
        last_ld = e.ld;
        // DONE ends; pipeline advances, so inputs change in the IDLE cycle.
        @(posedge clk); #1;
        m_MemRead = 1'b0; m_MemWrite = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_reissue: req=%b stall=%b required 0 0", name, dmem_req, stall);
        end
        $display("txn %s addr=%h we=%b be=%b wdata=%h load_data=%h stall_cycles=%0d",
                 name, e.addr, e.we, dmem_be, dmem_wdata, load_data, stalls);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({stall, misalign, bus_err, dmem_req, dmem_we} !== 5'b0 ||
            dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0 ||
            load_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: stall=%b mis=%b err=%b req=%b we=%b addr=%h be=%b wdata=%h ld=%h required all 0",
                     stall, misalign, bus_err, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_loads();
        issue("lw_0x100",  1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF, 4'h0, 0, 32'hDEADBEEF);
        issue("lb_0x103",  1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF0000, 4'h0, 0, 32'hFFFFFF80);
        issue("lbu_0x103", 1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF0000, 4'h0, 0, 32'h00000080);
        issue("lhu_0x102", 1, 0, 3'b101, 32'h102, 0, 0, 32'h80FF0000, 4'h0, 0, 32'h000080FF);
        issue("lh_0x102",  1, 0, 3'b001, 32'h102, 0, 0, 32'h80FF0000, 4'h0, 0, 32'hFFFF80FF);
        issue("lb_0x102",  1, 0, 3'b000, 32'h102, 0, 2, 32'h80FF0000, 4'h0, 0, 32'hFFFFFFFF);
        issue("lh_0x100",  1, 0, 3'b001, 32'h100, 0, 0, 32'h00007FFE, 4'h0, 0, 32'h00007FFE);
    endtask

    task automatic test_stores();
        // load_data must hold its previous value across stores
        issue("sb_0x201", 0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 32'h11111111, 4'b0010, 32'hABABABAB, last_ld);
        issue("sh_0x202", 0, 1, 3'b001, 32'h202, 32'h00001234, 1, 32'h22222222, 4'b1100, 32'h12341234, last_ld);
        issue("sw_rw",    1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 32'h33333333, 4'b1111, 32'hCAFEF00D, last_ld);
        issue("sb_0x200", 0, 1, 3'b000, 32'h200, 32'h000000FF, 0, 32'h0, 4'b0001, 32'hFFFFFFFF, last_ld);
        issue("sh_0x200", 0, 1, 3'b001, 32'h200, 32'hFFFF5678, 0, 32'h0, 4'b0011, 32'h56785678, last_ld);
    endtask

    task automatic test_misalign();
        logic [2:0]  f3_t [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [31:0] a_t  [4] = '{32'h102, 32'h105, 32'h201, 32'h100};
        logic        wr_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            m_MemRead = ~wr_t[i]; m_MemWrite = wr_t[i]; m_funct3 = f3_t[i];
            m_alu_out = a_t[i]; m_mem_data = 32'h0;
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL misalign%0d_stall: got %b required 0", i, stall);
            end
            @(posedge clk); #1;
            checks++;
            if (misalign !== 1'b1 || dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL misalign%0d_pulse: misalign=%b req=%b required 1 0", i, misalign, dmem_req);
            end
            m_MemRead = 1'b0; m_MemWrite = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (misalign !== 1'b0 || dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL misalign%0d_end: misalign=%b req=%b required 0 0", i, misalign, dmem_req);
            end
            $display("txn misalign f3=%b addr=%h", f3_t[i], a_t[i]);
        end
    endtask

    task automatic test_timeout();
        int n;
        m_MemRead = 1'b1; m_MemWrite = 1'b0; m_funct3 = 3'b010; m_alu_out = 32'h300;
        #1;
        @(posedge clk); #1;
        n = 0;
        while (dmem_req === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d required 4", n);
        end
        checks++;
        if (bus_err !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_bus_err: bus_err=%b stall=%b required 1 0", bus_err, stall);
        end
        checks++;
        if (load_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_load_data: got %h required 00000000", load_data);
        end
        last_ld = 32'h0;
        @(posedge clk); #1;
        m_MemRead = 1'b0;
        #1;
        checks++;
        if (bus_err !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: bus_err=%b req=%b stall=%b required 0 0 0", bus_err, dmem_req, stall);
        end
        $display("txn timeout addr=00000300 req_cycles=%0d", n);
    endtask

    task automatic test_reset_mid_req();
        m_MemRead = 1'b1; m_MemWrite = 1'b0; m_funct3 = 3'b010; m_alu_out = 32'h400;
        #1;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstreq_req: got %b required 1", dmem_req);
        end
        rst = 1'b1; m_MemRead = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL rstreq_abandon: req=%b stall=%b ld=%h required 0 0 00000000", dmem_req, stall, load_data);
        end
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL rstreq_late_ack: req=%b stall=%b ld=%h required 0 0 00000000", dmem_req, stall, load_data);
        end
        last_ld = 32'h0;
        $display("txn reset_mid_req addr=00000400");
    endtask

    task automatic test_back_to_back();
        issue("b2b_sw", 0, 1, 3'b010, 32'h500, 32'h0BADF00D, 0, 32'h0, 4'hF, 32'h0BADF00D, last_ld);
        issue("b2b_lw", 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0BADF00D, 4'h0, 0, 32'h0BADF00D);
        issue("b2b_lb", 1, 0, 3'b000, 32'h501, 32'h0, 0, 32'h0BADF00D, 4'h0, 0, 32'hFFFFFFF0);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
